// File: rtl/int_ctxt_stack_if.sv
// int_ctxt_stack_if: request, context and status signals between AP_ctrl and the context stack.
interface int_ctxt_stack_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int DATA_DEPTH     = 128,
    parameter int ADDR_WIDTH_MEM = 16,
    parameter int PASS_WIDTH     = 3,
    parameter int CNT_WIDTH      = 4
);
    logic                      int_set_i;
    logic                      ret_valid_i;
    logic                      err_clr_i;
    logic [ADDR_WIDTH_MEM-1:0] ret_addr_i;
    logic [ADDR_WIDTH_MEM-1:0] ctxt_addr_i;
    logic [DATA_WIDTH-1:0]     tmp_bit_cnt_i;
    logic [PASS_WIDTH-1:0]     tmp_pass_i;
    logic [DATA_WIDTH-1:0]     tmp_mask_i;
    logic [DATA_DEPTH-1:0]     tmp_C_F_i;
    logic                      push_ack_o;
    logic                      ctxt_rdy_o;
    logic [ADDR_WIDTH_MEM-1:0] ret_addr_ret_o;
    logic [ADDR_WIDTH_MEM-1:0] ctxt_addr_ret_o;
    logic [DATA_WIDTH-1:0]     tmp_bit_cnt_ret_o;
    logic [PASS_WIDTH-1:0]     tmp_pass_ret_o;
    logic [DATA_WIDTH-1:0]     tmp_mask_ret_o;
    logic [DATA_DEPTH-1:0]     tmp_C_F_ret_o;
    logic [CNT_WIDTH-1:0]      depth_o;
    logic                      full_o;
    logic                      empty_o;
    logic                      ovf_err_o;
    logic                      udf_err_o;

    modport master (
        output int_set_i, ret_valid_i, err_clr_i, ret_addr_i, ctxt_addr_i,
               tmp_bit_cnt_i, tmp_pass_i, tmp_mask_i, tmp_C_F_i,
        input  push_ack_o, ctxt_rdy_o, ret_addr_ret_o, ctxt_addr_ret_o,
               tmp_bit_cnt_ret_o, tmp_pass_ret_o, tmp_mask_ret_o, tmp_C_F_ret_o,
               depth_o, full_o, empty_o, ovf_err_o, udf_err_o
    );

    modport slave (
        input  int_set_i, ret_valid_i, err_clr_i, ret_addr_i, ctxt_addr_i,
               tmp_bit_cnt_i, tmp_pass_i, tmp_mask_i, tmp_C_F_i,
        output push_ack_o, ctxt_rdy_o, ret_addr_ret_o, ctxt_addr_ret_o,
               tmp_bit_cnt_ret_o, tmp_pass_ret_o, tmp_mask_ret_o, tmp_C_F_ret_o,
               depth_o, full_o, empty_o, ovf_err_o, udf_err_o
    );
endinterface

// File: rtl/int_ctxt_stack.sv
// int_ctxt_stack: AP context stack; edge-detected push on interrupt, pop on return, with
// a pending-pop flag so a return coinciding with an interrupt restores the just-pushed entry.
module int_ctxt_stack #(
    parameter int DATA_WIDTH     = 16,
    parameter int DATA_DEPTH     = 128,
    parameter int ADDR_WIDTH_MEM = 16,
    parameter int PASS_WIDTH     = 3,
    parameter int STACK_DEPTH    = 8,
    parameter int CNT_WIDTH      = 4
) (
    input logic               clk,
    input logic               rst,
    int_ctxt_stack_if.slave   bus
);
    localparam int EW = 2 * ADDR_WIDTH_MEM + 2 * DATA_WIDTH + PASS_WIDTH + DATA_DEPTH;
    localparam int IW = $clog2(STACK_DEPTH);

    typedef enum logic [1:0] {IDLE, PUSH, POP} state_e;

    state_e               state_q, state_d;
    logic                 int_q, ret_q, pop_pend_q, pop_pend_d;
    logic                 push_ack_q, ctxt_rdy_q, ovf_q, ovf_d, udf_q, udf_d;
    logic [CNT_WIDTH-1:0] depth_q, depth_d, top;
    logic [EW-1:0]        mem_q [STACK_DEPTH];
    logic [EW-1:0]        out_q, out_d, entry;
    logic                 push_ev, pop_ev, full, empty;
    logic                 do_push, do_pop, ovf_set, udf_set, pop_take;

    assign push_ev = bus.int_set_i & ~int_q;
    assign pop_ev  = bus.ret_valid_i & ~ret_q;
    assign full    = depth_q == CNT_WIDTH'(STACK_DEPTH);
    assign empty   = depth_q == '0;
    assign top     = depth_q - CNT_WIDTH'(1);
    assign entry   = {bus.ret_addr_i, bus.ctxt_addr_i, bus.tmp_bit_cnt_i,
                      bus.tmp_pass_i, bus.tmp_mask_i, bus.tmp_C_F_i};

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (push_ev ? PUSH : (pop_ev | pop_pend_q) ? POP : IDLE) : IDLE;
    end

    always_comb begin
        do_push  = (state_q == PUSH) && !full;
        ovf_set  = (state_q == PUSH) && full;
        do_pop   = (state_q == POP) && !empty;
        udf_set  = (state_q == POP) && empty;
        pop_take = (state_q == IDLE) && !push_ev && (pop_ev || pop_pend_q);
    end

    // A new error on the same edge as err_clr must survive the clear.
    always_comb begin
        pop_pend_d = pop_take ? 1'b0 : (pop_ev ? 1'b1 : pop_pend_q);
        depth_d    = do_push ? depth_q + CNT_WIDTH'(1) : do_pop ? top : depth_q;
        out_d      = do_pop ? mem_q[top[IW-1:0]] : out_q;
        ovf_d      = ovf_set | (ovf_q & ~bus.err_clr_i);
        udf_d      = udf_set | (udf_q & ~bus.err_clr_i);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            int_q      <= 1'b0;
            ret_q      <= 1'b0;
            pop_pend_q <= 1'b0;
            depth_q    <= '0;
            push_ack_q <= 1'b0;
            ctxt_rdy_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            out_q      <= '0;
        end else begin
            int_q      <= bus.int_set_i;
            ret_q      <= bus.ret_valid_i;
            pop_pend_q <= pop_pend_d;
            depth_q    <= depth_d;
            push_ack_q <= do_push;
            ctxt_rdy_q <= do_pop;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            out_q      <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) mem_q[depth_q[IW-1:0]] <= entry;
    end

    assign {bus.ret_addr_ret_o, bus.ctxt_addr_ret_o, bus.tmp_bit_cnt_ret_o,
            bus.tmp_pass_ret_o, bus.tmp_mask_ret_o, bus.tmp_C_F_ret_o} = out_q;
    assign bus.push_ack_o = push_ack_q;
    assign bus.ctxt_rdy_o = ctxt_rdy_q;
    assign bus.depth_o    = depth_q;
    assign bus.full_o     = full;
    assign bus.empty_o    = empty;
    assign bus.ovf_err_o  = ovf_q;
    assign bus.udf_err_o  = udf_q;
endmodule
